// File: rtl/mac_tx_arbiter_pkg.sv
// Shared constants for the MAC transmit arbiter.
// FSM encoding, default timing constants and an index-width helper.
package mac_tx_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_XFER = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam int IFG_DEFAULT     = 12;
  localparam int TIMEOUT_DEFAULT = 1024;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr.sv
// Round-robin pick: first requester above the last winner.
// Purely combinational; the caller registers the result.
module rr_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int IW    = idx_w(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    win,
  output logic             any
);

  logic [IW-1:0] cand [NPORT];

  // Search order: last+1, last+2, ... wrapping at NPORT.
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      cand[k] = IW'((int'(last) + k + 1) % NPORT);
    end
  end

  // Take the first candidate that is requesting.
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (!any && req[cand[k]]) begin
        any = 1'b1;
        gnt[cand[k]] = 1'b1;
        win = cand[k];
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-level arbiter from NPORT byte sources onto mac_rgmii.
// Whole frames are granted round-robin, then an inter-frame gap.
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int NPORT      = 4,
  parameter int IFG_CYCLES = IFG_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NPORT*8-1:0] src_data,
  input  logic [NPORT-1:0]   src_valid,
  input  logic [NPORT-1:0]   src_sof,
  input  logic [NPORT-1:0]   src_eof,
  output logic [NPORT-1:0]   src_ready,
  output logic [7:0]         mac_tx_data,
  output logic               mac_tx_valid,
  output logic               mac_tx_sof,
  output logic               mac_tx_eof,
  output logic [NPORT-1:0]   grant,
  output logic               err_timeout,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int IW = idx_w(NPORT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST =
    8'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);

  state_t           state;
  logic [IW-1:0]    last_winner;
  logic [15:0]      idle_cnt;
  logic [7:0]       gap_cnt;
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] stray;
  logic [NPORT-1:0] arb_gnt;
  logic [IW-1:0]    arb_win;
  logic             arb_any;
  logic             beat;
  logic [7:0]       own_data;
  logic             own_sof;
  logic             own_eof;

  assign req   = src_valid & src_sof;
  assign stray = src_valid & ~src_sof;
  assign beat  = (state == ST_XFER) && |(src_valid & grant);

  rr_arbiter #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_rr (
    .req  (req),
    .last (last_winner),
    .gnt  (arb_gnt),
    .win  (arb_win),
    .any  (arb_any)
  );

  // Mux the owner's beat onto a single byte lane.
  always_comb begin
    own_data = '0;
    own_sof  = 1'b0;
    own_eof  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant[i]) begin
        own_data = src_data[i*8 +: 8];
        own_sof  = src_sof[i];
        own_eof  = src_eof[i];
      end
    end
  end

  // Ready: drain strays in IDLE, owner only in XFER, none in GAP.
  always_comb begin
    src_ready = '0;
    if (rst_n) begin
      case (state)
        ST_IDLE: src_ready = stray;
        ST_XFER: src_ready = grant;
        default: src_ready = '0;
      endcase
    end
  end

  // Registered output stage, one cycle behind the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_tx_valid <= 1'b0;
      mac_tx_data  <= '0;
      mac_tx_sof   <= 1'b0;
      mac_tx_eof   <= 1'b0;
    end else begin
      mac_tx_valid <= beat;
      mac_tx_data  <= beat ? own_data : '0;
      mac_tx_sof   <= beat & own_sof;
      mac_tx_eof   <= beat & own_eof;
    end
  end

  // Count cycles in which any stray beat was thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (state == ST_IDLE && |stray) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Frame FSM: arbitrate, transfer with stall watchdog, gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_winner <= IW'(NPORT - 1);
      grant       <= '0;
      idle_cnt    <= '0;
      gap_cnt     <= '0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant       <= arb_gnt;
            last_winner <= arb_win;
            idle_cnt    <= '0;
            state       <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat) begin
            idle_cnt <= '0;
            if (own_eof) begin
              grant     <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end
          end else if (idle_cnt == TO_LAST) begin
            grant       <= '0;
            err_timeout <= 1'b1;
            idle_cnt    <= '0;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: frame-level reference model,
// per-port frame drivers and a cycle monitor on mac_tx.
module tb_mac_tx_arbiter;

  localparam int NP  = 4;
  localparam int IFG = 12;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*8-1:0] src_data = '0;
  logic [NP-1:0]   src_valid = '0;
  logic [NP-1:0]   src_sof = '0;
  logic [NP-1:0]   src_eof = '0;
  logic [NP-1:0]   src_ready;
  logic [7:0]      mac_tx_data;
  logic            mac_tx_valid;
  logic            mac_tx_sof;
  logic            mac_tx_eof;
  logic [NP-1:0]   grant;
  logic            err_timeout;
  logic [15:0]     frame_cnt;
  logic [15:0]     drop_cnt;

  always #5 clk = ~clk;

  mac_tx_arbiter #(
    .NPORT      (NP),
    .IFG_CYCLES (IFG),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_sof      (src_sof),
    .src_eof      (src_eof),
    .src_ready    (src_ready),
    .mac_tx_data  (mac_tx_data),
    .mac_tx_valid (mac_tx_valid),
    .mac_tx_sof   (mac_tx_sof),
    .mac_tx_eof   (mac_tx_eof),
    .grant        (grant),
    .err_timeout  (err_timeout),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int ncyc = 0;

  logic [9:0] mem [NP][256];
  int tot [NP];
  int pos [NP];
  int stall_at [NP];
  int gaprun [NP];
  int fst [NP][4];
  int fln [NP][4];
  int nfr [NP];
  int mfr [NP];
  bit rnd_gaps = 0;
  bit mon_en = 0;
  logic [NP-1:0] acc;
  logic [NP-1:0] rdy_s;
  logic [NP-1:0] prev_gnt = '0;

  logic [9:0] exp_q [$];
  int own_q [$];
  int gval_q [$];
  int gcyc_q [$];
  int eof_q [$];
  int m_last = NP - 1;
  int m_frames = 0;
  int last_eof = -1000;

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      logic [9:0] w;
      logic v;
      w = (pos[p] < tot[p]) ? mem[p][pos[p]] : 10'd0;
      v = (pos[p] < tot[p]) && (pos[p] < stall_at[p]);
      if (v && rnd_gaps && !w[9] && gaprun[p] < 3
          && $urandom_range(0, 3) == 0)
        v = 1'b0;
      gaprun[p] = v ? 0 : gaprun[p] + 1;
      src_valid[p] = v;
      src_sof[p] = v & w[9];
      src_eof[p] = v & w[8];
      src_data[p*8 +: 8] = v ? w[7:0] : 8'h00;
    end
  endtask

  task automatic monitor();
    logic ev;
    logic [9:0] got;
    logic [9:0] want;
    ev = (own_q.size() > 0) ? acc[own_q[0]] : 1'b0;
    got = {mac_tx_sof, mac_tx_eof, mac_tx_data};
    vectors++;
    if (mac_tx_valid !== ev) begin
      miscompares++;
      $display("FAIL tx_valid cyc %0d: got %b want %b",
               ncyc, mac_tx_valid, ev);
    end
    if (mac_tx_valid === 1'b1) begin
      want = 10'h3ff;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL tx_beat cyc %0d: got %h want %h",
                 ncyc, got, want);
      end
      if (want[8] && own_q.size() > 0) void'(own_q.pop_front());
      if (mac_tx_eof === 1'b1) begin
        eof_q.push_back(ncyc);
        last_eof = ncyc;
      end
    end else begin
      vectors++;
      if (got !== 10'd0) begin
        miscompares++;
        $display("FAIL tx_idle_zero cyc %0d: got %h want 000",
                 ncyc, got);
      end
    end
    if (ncyc - last_eof >= 0 && ncyc - last_eof < IFG) begin
      vectors++;
      if (src_ready !== '0) begin
        miscompares++;
        $display("FAIL gap_ready cyc %0d: got %b want 0000",
                 ncyc, src_ready);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    acc = src_valid & src_ready;
    rdy_s = src_ready;
    @(posedge clk);
    #1;
    ncyc++;
    for (int p = 0; p < NP; p++)
      if (acc[p] && pos[p] < tot[p]) pos[p]++;
    if (mon_en) monitor();
    if (grant != '0 && prev_gnt == '0) begin
      gval_q.push_back(int'(grant));
      gcyc_q.push_back(ncyc);
    end
    prev_gnt = grant;
    drive();
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      tot[p] = 0;
      pos[p] = 0;
      nfr[p] = 0;
      mfr[p] = 0;
      gaprun[p] = 0;
      stall_at[p] = 1000;
    end
    rnd_gaps = 0;
    drive();
  endtask

  task automatic add_frame(input int p, input int len,
                           input int fixed);
    fst[p][nfr[p]] = tot[p];
    fln[p][nfr[p]] = len;
    nfr[p]++;
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      if (fixed >= 0) d = 8'(fixed);
      else d = 8'($urandom_range(0, 255));
      mem[p][tot[p]] = {(i == 0), (i == len - 1), d};
      tot[p]++;
    end
  endtask

  // Whole-frame round robin over every port with frames waiting.
  task automatic build_expect();
    int left;
    left = 0;
    for (int p = 0; p < NP; p++) left += nfr[p] - mfr[p];
    while (left > 0) begin
      int w;
      w = -1;
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (m_last + k) % NP;
        if (w < 0 && mfr[c] < nfr[c]) w = c;
      end
      for (int i = 0; i < fln[w][mfr[w]]; i++)
        exp_q.push_back(mem[w][fst[w][mfr[w]] + i]);
      own_q.push_back(w);
      mfr[w]++;
      m_last = w;
      m_frames++;
      left--;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mon_en = 0;
    clear_src();
    exp_q.delete();
    own_q.delete();
    gval_q.delete();
    gcyc_q.delete();
    eof_q.delete();
    m_last = NP - 1;
    m_frames = 0;
    last_eof = -1000;
    repeat (2) cyc();
    rst_n = 1'b1;
    mon_en = 1;
  endtask

  task automatic run_frames(input int budget, input string tag);
    int n;
    n = 0;
    while (own_q.size() > 0 && n < budget) begin
      cyc();
      n++;
    end
    vectors++;
    if (own_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_done: %0d frames left, want 0",
               tag, own_q.size());
    end
  endtask

  task automatic chk_zero(input string tag);
    vectors++;
    if ({grant, src_ready, mac_tx_valid, mac_tx_sof,
         mac_tx_eof, mac_tx_data, err_timeout} !== '0) begin
      miscompares++;
      $display("FAIL %s_outs: gnt %b rdy %b v%b s%b e%b d%h err%b want 0",
               tag, grant, src_ready, mac_tx_valid, mac_tx_sof,
               mac_tx_eof, mac_tx_data, err_timeout);
    end
    vectors++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL %s_cnts: frame %0d drop %0d want 0 0",
               tag, frame_cnt, drop_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_src();
    src_valid = '1;
    src_sof = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    do_reset();
    cyc();
    chk_zero("post_reset");
  endtask

  task automatic test_two_port();
    do_reset();
    add_frame(0, $urandom_range(8, 32), -1);
    add_frame(2, $urandom_range(8, 32), -1);
    build_expect();
    run_frames(600, "two_port");
    vectors++;
    if (gval_q.size() < 2 || eof_q.size() < 1) begin
      miscompares++;
      $display("FAIL two_port_grants: got %0d grants want 2",
               gval_q.size());
    end else begin
      vectors++;
      if (gval_q[0] != 1 || gval_q[1] != 4) begin
        miscompares++;
        $display("FAIL two_port_order: got %0d,%0d want 1,4",
                 gval_q[0], gval_q[1]);
      end
      vectors++;
      if (gcyc_q[1] - eof_q[0] != IFG + 1) begin
        miscompares++;
        $display("FAIL two_port_ifg: got %0d want %0d",
                 gcyc_q[1] - eof_q[0], IFG + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    int want [5];
    want = '{1, 2, 4, 8, 1};
    do_reset();
    for (int p = 0; p < NP; p++) add_frame(p, 64, -1);
    add_frame(0, 64, -1);
    build_expect();
    run_frames(2000, "rr");
    vectors++;
    if (gval_q.size() != 5) begin
      miscompares++;
      $display("FAIL rr_grants: got %0d want 5", gval_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (gval_q[i] != want[i]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got %0d want %0d",
                   i, gval_q[i], want[i]);
        end
      end
    end
    vectors++;
    if (frame_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL rr_frame_cnt: got %0d want 5", frame_cnt);
    end
  endtask

  task automatic test_one_byte();
    int n;
    bit hit;
    do_reset();
    add_frame(1, 1, 'hA5);
    build_expect();
    n = 0;
    hit = 0;
    while (!hit && n < 50) begin
      cyc();
      n++;
      if (mac_tx_valid === 1'b1) begin
        hit = 1;
        vectors++;
        if ({mac_tx_sof, mac_tx_eof, mac_tx_data} !== 10'h3A5) begin
          miscompares++;
          $display("FAIL one_byte_beat: got %b%b%h want 11a5",
                   mac_tx_sof, mac_tx_eof, mac_tx_data);
        end
        vectors++;
        if (grant !== '0 || src_ready !== '0) begin
          miscompares++;
          $display("FAIL one_byte_gap: gnt %b rdy %b want 0 0",
                   grant, src_ready);
        end
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL one_byte_seen: got none want 1 beat");
    end
    cyc();
    vectors++;
    if (mac_tx_valid !== 1'b0 || frame_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL one_byte_after: v %b frames %0d want 0 1",
               mac_tx_valid, frame_cnt);
    end
  endtask

  task automatic test_timeout();
    int last_acc, to_cyc, errs, nbeat, eofs;
    do_reset();
    mon_en = 0;
    add_frame(3, 6, -1);
    stall_at[3] = 2;
    drive();
    last_acc = -1;
    to_cyc = -1;
    errs = 0;
    nbeat = 0;
    eofs = 0;
    for (int n = 0; n < 200; n++) begin
      cyc();
      if (acc[3]) last_acc = ncyc;
      if (mac_tx_valid === 1'b1) nbeat++;
      if (mac_tx_eof === 1'b1) eofs++;
      if (err_timeout === 1'b1) begin
        errs++;
        if (to_cyc < 0) begin
          to_cyc = ncyc;
          vectors++;
          if (grant !== '0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL to_state: gnt %b frames %0d want 0 0",
                     grant, frame_cnt);
          end
        end
      end
      if (to_cyc >= 0 && ncyc > to_cyc + 5) break;
    end
    vectors++;
    if (to_cyc < 0 || to_cyc - last_acc != TO) begin
      miscompares++;
      $display("FAIL to_delay: got %0d want %0d",
               (to_cyc < 0) ? -1 : to_cyc - last_acc, TO);
    end
    vectors++;
    if (errs != 1) begin
      miscompares++;
      $display("FAIL to_pulse: got %0d cycles want 1", errs);
    end
    vectors++;
    if (nbeat != 2 || eofs != 0) begin
      miscompares++;
      $display("FAIL to_beats: got %0d beats %0d eof want 2 0",
               nbeat, eofs);
    end
  endtask

  task automatic test_stray();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src_valid = 4'b0010;
      src_sof = '0;
      src_data = NP*8'($urandom);
      cyc();
      vectors++;
      if (rdy_s !== 4'b0010 || mac_tx_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stray_rdy[%0d]: rdy %b v %b want 0010 0",
                 i, rdy_s, mac_tx_valid);
      end
    end
    vectors++;
    if (drop_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL stray_cnt3: got %0d want 3", drop_cnt);
    end
    src_valid = 4'b0110;
    src_sof = '0;
    cyc();
    vectors++;
    if (drop_cnt !== 16'd4 || rdy_s !== 4'b0110) begin
      miscompares++;
      $display("FAIL stray_two: cnt %0d rdy %b want 4 0110",
               drop_cnt, rdy_s);
    end
    src_valid = 4'b0110;
    src_sof = 4'b0100;
    cyc();
    vectors++;
    if (drop_cnt !== 16'd5 || rdy_s !== 4'b0010
        || grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL stray_req: cnt %0d rdy %b gnt %b want 5 0010 0100",
               drop_cnt, rdy_s, grant);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_frame(2, 100, -1);
    build_expect();
    repeat (40) cyc();
    vectors++;
    if (mac_tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_active: got %b want 1", mac_tx_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    do_reset();
    add_frame(2, 10, -1);
    add_frame(0, 10, -1);
    build_expect();
    run_frames(300, "mid_next");
    vectors++;
    if (gval_q.size() < 1 || gval_q[0] != 1) begin
      miscompares++;
      $display("FAIL mid_first_grant: got %0d want 1",
               (gval_q.size() < 1) ? 0 : gval_q[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      int sub;
      clear_src();
      rnd_gaps = 1;
      sub = $urandom_range(1, 15);
      for (int p = 0; p < NP; p++) begin
        if (sub[p]) begin
          int k;
          k = $urandom_range(1, 2);
          for (int f = 0; f < k; f++)
            add_frame(p, $urandom_range(1, 24), -1);
        end
      end
      build_expect();
      run_frames(3000, "random");
    end
    vectors++;
    if (frame_cnt !== 16'(m_frames)) begin
      miscompares++;
      $display("FAIL rand_frame_cnt: got %0d want %0d",
               frame_cnt, m_frames);
    end
  endtask

  initial begin
    test_reset();
    test_two_port();
    test_round_robin();
    test_one_byte();
    test_timeout();
    test_stray();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
